// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide-unit controller.
// Optional feature macro used by the controller: MDU_ACC_EN (MADD/MADDU/MSUB/MSUBU).
package mdu_pkg;

  // Operation codes presented on the op port.
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_MTHI  = 3'd2,
    MDU_MTLO  = 3'd3,
    MDU_MADD  = 3'd4,
    MDU_MADDU = 3'd5,
    MDU_MSUB  = 3'd6,
    MDU_MSUBU = 3'd7
  } mdu_op_e;

  // Controller states.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  // How the product is folded into HI/LO on the result edge.
  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2
  } mdu_acc_e;

  // Legal multiply latency range and the counter width that covers it.
  localparam int unsigned MUL_LAT_MIN = 1;
  localparam int unsigned MUL_LAT_MAX = 16;
  localparam int unsigned CNT_W       = 4;

endpackage

// File: rtl/mdu_ctrl_multiplier.sv
// Combinational 32x32 -> 64 multiplier, signed or unsigned by the sign input.
// Driven only from stable, latched operands, so it is timed as a multicycle path.
module mdu_ctrl_multiplier (
  input  logic        sign,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  output logic [63:0] oZ
);

  logic [63:0] a_ext;
  logic [63:0] b_ext;

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
  // exact for both interpretations, and a 32x32 product never overflows 64 bits.
  always_comb begin
    a_ext = {{32{sign & iA[31]}}, iA};
    b_ext = {{32{sign & iB[31]}}, iB};
    oZ    = a_ext * b_ext;
  end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO owner and multiply sequencer for the multicycle core.
// Executes MULT/MULTU/MTHI/MTLO; with MDU_ACC_EN defined also MADD/MADDU/MSUB/MSUBU.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        abort,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  if (MUL_LAT < MUL_LAT_MIN || MUL_LAT > MUL_LAT_MAX) begin : g_bad_lat
    $error("mdu_ctrl: MUL_LAT out of range 1..16");
  end

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic             sign_q, sign_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             done_q, done_d;
  mdu_acc_e         acc_q, acc_d;
  logic [63:0]      product;
  logic [63:0]      result;
  logic             accept;
  mdu_op_e          op_e;

  mdu_ctrl_multiplier u_mult (
    .sign (sign_q),
    .iA   (a_q),
    .iB   (b_q),
    .oZ   (product)
  );

  // Value written to {hi,lo} on the result edge.
`ifdef MDU_ACC_EN
  always_comb begin
    result = product;
    unique case (acc_q)
      ACC_ADD: result = {hi_q, lo_q} + product;
      ACC_SUB: result = {hi_q, lo_q} - product;
      default: result = product;
    endcase
  end
`else
  always_comb begin
    result = product;
  end
`endif

  // Issue qualification and status outputs.
  always_comb begin
    op_e   = mdu_op_e'(op);
    accept = start && (state_q == IDLE) && !abort;
    ready  = (state_q == IDLE);
    busy   = (state_q == RUN);
    done   = done_q;
    hi     = hi_q;
    lo     = lo_q;
  end

  // Next-state logic: issue decode in IDLE, countdown and writeback in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          case (op_e)
            MDU_MULT, MDU_MULTU: begin
              a_d     = rs_val;
              b_d     = rt_val;
              sign_d  = (op_e == MDU_MULT);
              acc_d   = ACC_NONE;
              cnt_d   = CNT_W'(MUL_LAT - 1);
              state_d = RUN;
            end
            MDU_MTHI: hi_d = rs_val;
            MDU_MTLO: lo_d = rs_val;
`ifdef MDU_ACC_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: begin
              a_d     = rs_val;
              b_d     = rt_val;
              sign_d  = (op_e == MDU_MADD) || (op_e == MDU_MSUB);
              acc_d   = ((op_e == MDU_MADD) || (op_e == MDU_MADDU)) ? ACC_ADD : ACC_SUB;
              cnt_d   = CNT_W'(MUL_LAT - 1);
              state_d = RUN;
            end
`endif
            default: ; // undefined op: accepted, no effect
          endcase
        end
      end
      RUN: begin
        if (abort) begin
          // Flush: drop the partial result, HI/LO keep their old value.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = result;
          state_d      = IDLE;
          done_d       = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand latches and architectural HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      acc_q   <= ACC_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl (MUL_LAT=4 main instance, MUL_LAT=1 second instance).
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start, abort;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        ready, busy, done;
  logic [31:0] hi, lo;

  logic        start1, abort1;
  logic [2:0]  op1;
  logic [31:0] rs1, rt1;
  logic        ready1, busy1, done1;
  logic [31:0] hi1, lo1;

  int checks = 0;
  int errors = 0;

  mdu_ctrl #(.MUL_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .abort(abort), .ready(ready), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mdu_ctrl #(.MUL_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .rs_val(rs1), .rt_val(rt1),
    .abort(abort1), .ready(ready1), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one issue cycle; returns at the falling edge after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Following issue(): expect exactly 4 busy cycles, then a one-cycle done with the result.
  task automatic expect_result(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    int busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy && !done) busy_cnt++;
      @(negedge clk);
    end
    check({tag, " busy cycles"}, busy_cnt, 4);
    check({tag, " done"}, {busy, done}, 2'b01);
    check({tag, " hi"}, hi, ehi);
    check({tag, " lo"}, lo, elo);
    @(negedge clk);
    check({tag, " done drop"}, done, 0);
  endtask

  // Watch for n cycles and report whether done ever pulsed.
  task automatic no_done(input string tag, input int n);
    logic seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      seen |= done;
      @(negedge clk);
    end
    check(tag, seen, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = '0; rs_val = '0; rt_val = '0;
    start1 = 1'b0; abort1 = 1'b0; op1 = '0; rs1 = '0; rt1 = '0;
    #12;
    check("reset ready/busy/done", {ready, busy, done}, 3'b100);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Signed and unsigned multiplies.
    issue(MDU_MULT, 32'hFFFF_FFFD, 32'd5);
    check("mult accepted", {ready, busy}, 2'b01);
    expect_result("mult -3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
    expect_result("multu", 32'h0000_0001, 32'hFFFF_FFFE);
    issue(MDU_MULT, 32'hFFFF_FFFF, 32'd2);
    expect_result("mult -1x2", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // MTHI then MTLO back to back.
    @(negedge clk);
    start = 1'b1; op = MDU_MTHI; rs_val = 32'h1234_5678;
    @(negedge clk);
    check("mthi hi", hi, 32'h1234_5678);
    check("mthi ready/done", {ready, done}, 2'b10);
    op = MDU_MTLO; rs_val = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    check("mtlo lo", lo, 32'h9ABC_DEF0);
    check("mtlo hi kept", hi, 32'h1234_5678);
    check("mtlo ready/done", {ready, done}, 2'b10);

    // Start during RUN is dropped, not queued.
    issue(MDU_MULT, 32'd2, 32'd3);
    @(negedge clk);
    start = 1'b1; op = MDU_MULT; rs_val = 32'd7; rt_val = 32'd9;
    @(negedge clk);
    start = 1'b0;
    check("run ignores start", busy, 1);
    @(negedge clk);
    @(negedge clk);
    check("first result on time", {done, hi, lo}, {1'b1, 32'd0, 32'd6});
    @(negedge clk);
    check("second not queued", {busy, ready, lo}, {1'b0, 1'b1, 32'd6});
    issue(MDU_MULT, 32'd7, 32'd9);
    expect_result("mult 7x9", 32'd0, 32'd63);

    // Abort mid-run keeps HI/LO; abort beats a coincident start in IDLE.
    issue(MDU_MTHI, 32'h0000_AAAA, 32'd0);
    issue(MDU_MTLO, 32'h0000_5555, 32'd0);
    issue(MDU_MULT, 32'd7, 32'd9);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort to idle", {ready, busy, done}, 3'b100);
    no_done("abort no done", 6);
    check("abort hi kept", hi, 32'h0000_AAAA);
    check("abort lo kept", lo, 32'h0000_5555);
    @(negedge clk);
    start = 1'b1; abort = 1'b1; op = MDU_MTHI; rs_val = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort+start dropped", {hi, busy}, {32'h0000_AAAA, 1'b0});

`ifdef MDU_ACC_EN
    issue(MDU_MTHI, 32'd0, 32'd0);
    issue(MDU_MTLO, 32'h10, 32'd0);
    issue(MDU_MADD, 32'd2, 32'd3);
    expect_result("madd", 32'd0, 32'h16);
    issue(MDU_MSUB, 32'h20, 32'd1);
    expect_result("msub", 32'hFFFF_FFFF, 32'hFFFF_FFF6);
`else
    issue(MDU_MADD, 32'd2, 32'd3);
    check("madd noop idle", {ready, busy}, 2'b10);
    no_done("madd noop no done", 6);
    check("madd noop hilo", {hi, lo}, {32'h0000_AAAA, 32'h0000_5555});
`endif

    // Reset in the middle of a run clears everything at once.
    issue(MDU_MULT, 32'd7, 32'd9);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun reset status", {ready, busy, done}, 3'b100);
    check("midrun reset hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    no_done("midrun reset no done", 6);

    // MUL_LAT=1: result one cycle after accept.
    @(negedge clk);
    start1 = 1'b1; op1 = MDU_MULT; rs1 = 32'hFFFF_FFFD; rt1 = 32'd5;
    @(negedge clk);
    start1 = 1'b0;
    check("lat1 busy", {busy1, done1}, 2'b10);
    @(negedge clk);
    check("lat1 done", {busy1, done1, ready1}, 3'b011);
    check("lat1 result", {hi1, lo1}, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
    @(negedge clk);
    check("lat1 done drop", done1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencing controller for the 32x32 combinational Multiplier inside the multicycle MIPS core.
- Owns the architectural HI/LO registers and executes MULT, MULTU, MTHI and MTLO.
- Operands are latched at issue and held stable, so the Multiplier runs as a MUL_LAT-cycle multicycle path.
- Exposes busy/ready to the main control FSM so that MFHI/MFLO and new MDU ops stall correctly.

Parameters:
- MUL_LAT, 4, cycles from issue to HI/LO update for multiplies; legal range 1..16.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  issue request, qualified by ready
- op  in  3  operation code (package enum)
- rs_val  in  32  operand A / MTHI-MTLO source
- rt_val  in  32  operand B
- abort  in  1  flush of the in-flight multiply (exception)
- ready  out  1  high when an issue can be accepted
- busy  out  1  multiply in flight
- done  out  1  one-cycle pulse after HI/LO multiply update
- hi  out  32  HI register (MFHI source)
- lo  out  32  LO register (MFLO source)

Behaviour:
- Reset (async, rst_n low): state=IDLE, hi=0, lo=0, cnt=0, busy=0, done=0, ready=1, operand latches=0.
- Issue is accepted on a rising edge where start && ready && !abort. Any start that does not meet this is ignored and not queued.
- ready = (state==IDLE). busy = (state==RUN).
- MTHI/MTLO: hi (or lo) <= rs_val at the accept edge. State stays IDLE, no done pulse, ready stays 1.
- MULT/MULTU: at the accept edge:
  - latch A=rs_val, B=rt_val, sign=(op==MULT);
  - cnt <= MUL_LAT-1; state <= RUN.
- Multiplier is instantiated on the latched operands only.
- RUN: cnt decrements each edge. On the edge where cnt==0: {hi,lo} <= product[63:32],product[31:0]; state <= IDLE; done <= 1 for exactly the next cycle.
- Latency: new hi/lo are visible exactly MUL_LAT cycles after the accept edge. With MUL_LAT=1 the RUN state lasts one cycle.
- Signed product is two's complement, 64 bits, and never overflows.
- Undefined op codes: accepted as a no-op (1 cycle, no state change).
- abort while RUN: state <= IDLE, hi/lo unchanged, no done.
- abort in IDLE: no effect; a coincident start is dropped (abort wins).
- start while RUN: ignored; the controller does not latch or queue it.
- rst_n asserted mid-RUN: immediate clear to reset values; the partial result is lost.
- done is registered and deasserts the cycle after it fires, even if a new start is accepted in that same cycle.

Optional Feature:
- Macro MDU_ACC_EN.
- Defined: op also accepts MADD, MADDU, MSUB and MSUBU. The result edge writes {hi,lo} <= {hi,lo} ± product, mod 2^64, using the HI/LO value current at the result edge. Timing and abort rules are identical to MULT.
- Undefined: these codes are treated as undefined ops (no-op), and no 64-bit adder is synthesised.

Decomposition:
- Package mdu_pkg holds:
  - op enum: MDU_MULT=0, MDU_MULTU=1, MDU_MTHI=2, MDU_MTLO=3, MDU_MADD=4, MDU_MADDU=5, MDU_MSUB=6, MDU_MSUBU=7;
  - state enum: IDLE, RUN;
  - MUL_LAT bounds.
- The one natural sub-module is the existing Multiplier (sign, iA, iB, oZ), instantiated unchanged.
- Counter and FSM stay in mdu_ctrl.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5, MUL_LAT=4 → busy for 4 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, 1-cycle done.
- MULTU rs=0xFFFFFFFF, rt=2 → hi=0x00000001, lo=0xFFFFFFFE; MULT with the same operands → hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles → hi/lo update the next edge, ready stays 1, no done.
- start MULT 7x9 issued 2 cycles into a RUN → ignored; the first result lands on schedule; the second is accepted only once ready=1.
- abort at cycle 2 of RUN (prior hi/lo=0xAAAA/0x5555) → IDLE next edge, hi/lo unchanged, no done; abort+start together in IDLE → nothing accepted.
- MDU_ACC_EN build: hi/lo=0/0x10, MADD 2x3 → lo=0x16; then MSUB 0x20x1 → hi=0xFFFFFFFF, lo=0xFFFFFFF6. Repeat MULT -3x5 with MUL_LAT=1 → result after 1 cycle.
